// File: rtl/rs_eint_pkg.sv
// rs_eint_pkg: shared types, sizes and the dispatch-time source-ready rule for the integer reservation station
package rs_eint_pkg;
  localparam int NUM_RS_ENTRIES_DEFAULT = 8;
  localparam int NUM_SOURCES = 2;
  typedef logic [$clog2(NUM_RS_ENTRIES_DEFAULT)-1:0] t_rs_id;
  typedef logic [5:0] t_prf_id;
  typedef logic [4:0] t_opreg;
  typedef logic [4:0] t_rob_id;
  typedef struct packed {
    logic [7:0] opcode;
    t_opreg dst;
    t_opreg [NUM_SOURCES-1:0] src;
  } t_uinstr;
  typedef struct packed {
    t_prf_id pdst;
    t_prf_id [NUM_SOURCES-1:0] psrc;
  } t_rename;
  typedef struct packed {
    t_uinstr uinstr;
    t_rob_id robid;
    t_rename rename;
  } t_uinstr_disp;
  // a source is ready on write if alloc says so, it is being written back right now, or it reads opreg 0
  function automatic logic src_rdy_on_write(input logic rdy, input logic wb_v, input t_prf_id wb_p,
                                            input t_prf_id psrc, input t_opreg opreg);
    return rdy | (wb_v && wb_p == psrc) | (opreg == '0);
  endfunction
endpackage

// File: rtl/rs_eint_age_matrix.sv
// rs_age_matrix: pairwise age tracking and oldest-eligible pick for the reservation station
module rs_age_matrix #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [$clog2(N)-1:0] i_wr_id,
  input  logic [N-1:0]         i_eligible,
  output logic [$clog2(N)-1:0] o_sel_id
);
  localparam int IW = $clog2(N);
  logic [N-1:0] r_older [N];
  // a newly written entry is younger than every other entry
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < N; i++) r_older[i] <= '0;
    else if (i_wr_en)
      for (int i = 0; i < N; i++)
        if (IW'(i) == i_wr_id) r_older[i] <= '0;
        else r_older[i][i_wr_id] <= 1'b1;
  // the oldest eligible entry is older than every other eligible entry
  always_comb begin
    o_sel_id = '0;
    for (int i = 0; i < N; i++)
      o_sel_id = (i_eligible[i] && &(r_older[i] | ~i_eligible | (N'(1) << i))) ? IW'(i) : o_sel_id;
  end
endmodule

// File: rtl/rs_eint.sv
// rs_eint: integer reservation station with wakeup, issue select and flush; RS_AGE_ORDER_EN selects oldest-first issue
module rs_eint import rs_eint_pkg::*; #(
  parameter int NUM_RS_ENTRIES = NUM_RS_ENTRIES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   disp_valid_ex_rs0,
  input  t_uinstr_disp           disp_ex_rs0,
  input  logic [NUM_SOURCES-1:0] src_rdy_ex_rs0,
  output logic                   rs_stall_ex_rs0,
  input  logic                   wb_valid_rb0,
  input  t_prf_id                wb_pdst_rb0,
  input  logic                   nuke_rb1,
  input  logic                   ex_stall_rs1,
  output logic                   issue_valid_rs1,
  output t_uinstr_disp           issue_rs1
);
  localparam int IW = $clog2(NUM_RS_ENTRIES);
  logic [NUM_RS_ENTRIES-1:0] r_valid;
  t_uinstr_disp              r_payload [NUM_RS_ENTRIES];
  logic [NUM_SOURCES-1:0]    r_rdy [NUM_RS_ENTRIES];
  logic [NUM_RS_ENTRIES-1:0] w_eligible;
  logic [IW-1:0]             w_free_id;
  logic [IW-1:0]             w_sel_id;
  logic                      w_disp;
  logic                      w_issue;

  for (genvar e = 0; e < NUM_RS_ENTRIES; e++) begin : g_elig
    assign w_eligible[e] = r_valid[e] & (&r_rdy[e]);
  end

  assign rs_stall_ex_rs0 = &r_valid;
  assign issue_valid_rs1 = (|w_eligible) & ~nuke_rb1;
  assign issue_rs1       = issue_valid_rs1 ? r_payload[w_sel_id] : '0;
  assign w_disp          = disp_valid_ex_rs0 & ~rs_stall_ex_rs0 & ~nuke_rb1;
  assign w_issue         = issue_valid_rs1 & ~ex_stall_rs1;

  // lowest-index free entry receives the next dispatch
  always_comb begin
    w_free_id = '0;
    for (int i = NUM_RS_ENTRIES-1; i >= 0; i--) w_free_id = r_valid[i] ? w_free_id : IW'(i);
  end

`ifdef RS_AGE_ORDER_EN
  rs_age_matrix #(.N(NUM_RS_ENTRIES)) u_age (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_disp),
    .i_wr_id    (w_free_id),
    .i_eligible (w_eligible),
    .o_sel_id   (w_sel_id)
  );
`else
  // lowest-index eligible entry issues
  always_comb begin
    w_sel_id = '0;
    for (int i = NUM_RS_ENTRIES-1; i >= 0; i--) w_sel_id = w_eligible[i] ? IW'(i) : w_sel_id;
  end
`endif

  // occupancy: flush clears everything, otherwise free the issued entry and claim the dispatched one
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_valid <= '0;
    else if (nuke_rb1) r_valid <= '0;
    else begin
      if (w_issue) r_valid[w_sel_id] <= 1'b0;
      if (w_disp) r_valid[w_free_id] <= 1'b1;
    end

  // payload capture on dispatch and wakeup of waiting sources on writeback
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_RS_ENTRIES; i++)
      if (w_disp && w_free_id == IW'(i)) begin
        r_payload[i] <= disp_ex_rs0;
        for (int s = 0; s < NUM_SOURCES; s++)
          r_rdy[i][s] <= src_rdy_on_write(src_rdy_ex_rs0[s], wb_valid_rb0, wb_pdst_rb0,
                                          disp_ex_rs0.rename.psrc[s], disp_ex_rs0.uinstr.src[s]);
      end else if (r_valid[i] && wb_valid_rb0)
        for (int s = 0; s < NUM_SOURCES; s++)
          if (r_payload[i].rename.psrc[s] == wb_pdst_rb0) r_rdy[i][s] <= 1'b1;

`ifdef SIMULATION
  // trace each accepted issue alongside the other pipeline units
  always_ff @(posedge clk)
    if (w_issue) $display("UINFO unit:RS robid:0x%0h pdst:0x%0h", issue_rs1.robid, issue_rs1.rename.pdst);
`endif
endmodule

// File: tb/tb_rs_eint.sv
// tb_rs_eint: directed and randomized checks of rs_eint against a slot-level reference model
module tb_rs_eint;
  import rs_eint_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic disp_valid_ex_rs0 = 1'b0;
  t_uinstr_disp disp_ex_rs0 = '0;
  logic [NUM_SOURCES-1:0] src_rdy_ex_rs0 = '0;
  logic rs_stall_ex_rs0;
  logic wb_valid_rb0 = 1'b0;
  t_prf_id wb_pdst_rb0 = '0;
  logic nuke_rb1 = 1'b0;
  logic ex_stall_rs1 = 1'b0;
  logic issue_valid_rs1;
  t_uinstr_disp issue_rs1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rs_eint #(.NUM_RS_ENTRIES(N)) dut (
    .clk(clk), .reset(reset),
    .disp_valid_ex_rs0(disp_valid_ex_rs0), .disp_ex_rs0(disp_ex_rs0), .src_rdy_ex_rs0(src_rdy_ex_rs0),
    .rs_stall_ex_rs0(rs_stall_ex_rs0),
    .wb_valid_rb0(wb_valid_rb0), .wb_pdst_rb0(wb_pdst_rb0),
    .nuke_rb1(nuke_rb1), .ex_stall_rs1(ex_stall_rs1),
    .issue_valid_rs1(issue_valid_rs1), .issue_rs1(issue_rs1)
  );

  // reference model: slots with an arrival stamp for age ordering
  logic                   m_valid [N];
  t_uinstr_disp           m_pay [N];
  logic [NUM_SOURCES-1:0] m_rdy [N];
  int                     m_age [N];
  int                     m_seq = 0;

  function automatic int m_sel();
    int best = -1;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && &m_rdy[i]) begin
`ifdef RS_AGE_ORDER_EN
        if (best < 0 || m_age[i] < m_age[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    return best;
  endfunction

  function automatic logic m_full();
    int cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m_valid[i]);
    return cnt == N;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_edge();
    int sel = m_sel();
    logic full = m_full();
    int fr = -1;
    if (nuke_rb1) begin
      m_clear();
      return;
    end
    for (int i = N-1; i >= 0; i--) if (!m_valid[i]) fr = i;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && wb_valid_rb0)
        for (int s = 0; s < NUM_SOURCES; s++)
          if (m_pay[i].rename.psrc[s] == wb_pdst_rb0) m_rdy[i][s] = 1'b1;
    if (sel >= 0 && !ex_stall_rs1) m_valid[sel] = 1'b0;
    if (disp_valid_ex_rs0 && !full) begin
      m_valid[fr] = 1'b1;
      m_pay[fr] = disp_ex_rs0;
      for (int s = 0; s < NUM_SOURCES; s++)
        m_rdy[fr][s] = src_rdy_ex_rs0[s] | (wb_valid_rb0 && wb_pdst_rb0 == disp_ex_rs0.rename.psrc[s])
                       | (disp_ex_rs0.uinstr.src[s] == 0);
      m_age[fr] = m_seq;
      m_seq++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sel = m_sel();
    logic iv = (sel >= 0) && !nuke_rb1;
    chk("issue_valid", issue_valid_rs1, iv);
    chk("issue_uop", issue_rs1, iv ? m_pay[sel] : '0);
    chk("stall", rs_stall_ex_rs0, m_full());
  endtask

  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid_ex_rs0 = 1'b0;
    src_rdy_ex_rs0 = '0;
    wb_valid_rb0 = 1'b0;
    wb_pdst_rb0 = '0;
    nuke_rb1 = 1'b0;
    ex_stall_rs1 = 1'b0;
  endtask

  function automatic t_uinstr_disp mk(input t_rob_id robid, input t_prf_id p0, input t_prf_id p1,
                                      input t_opreg o0, input t_opreg o1);
    t_uinstr_disp u;
    u.uinstr.opcode = 8'($urandom);
    u.uinstr.dst = 5'($urandom);
    u.uinstr.src[0] = o0;
    u.uinstr.src[1] = o1;
    u.robid = robid;
    u.rename.pdst = 6'($urandom);
    u.rename.psrc[0] = p0;
    u.rename.psrc[1] = p1;
    return u;
  endfunction

  task automatic disp(input t_uinstr_disp u, input logic [NUM_SOURCES-1:0] rdy);
    disp_valid_ex_rs0 = 1'b1;
    disp_ex_rs0 = u;
    src_rdy_ex_rs0 = rdy;
  endtask

  initial begin
    t_rob_id a_id;
    t_rob_id b_id;
    m_clear();
    idle();
    // reset held low across two edges
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_issue_valid", issue_valid_rs1, 0);
    chk("rst_stall", rs_stall_ex_rs0, 0);
    chk("rst_issue_uop", issue_rs1, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // dispatch with both sources ready issues next cycle and frees the cycle after
    disp(mk(5'h3, 6'h01, 6'h02, 5'd1, 5'd2), 2'b11);
    step();
    idle();
    #1;
    chk("lat_issue_valid", issue_valid_rs1, 1);
    chk("lat_robid", issue_rs1.robid, 5'h3);
    step();
    #1 chk("lat_freed", issue_valid_rs1, 0);
    step();

    // wakeup two cycles after dispatch issues one cycle after the wakeup
    disp(mk(5'h4, 6'h09, 6'h05, 5'd3, 5'd4), 2'b01);
    step();
    idle();
    step();
    wb_valid_rb0 = 1'b1;
    wb_pdst_rb0 = 6'h05;
    #1 chk("wake_before", issue_valid_rs1, 0);
    step();
    idle();
    #1;
    chk("wake_issue", issue_valid_rs1, 1);
    chk("wake_robid", issue_rs1.robid, 5'h4);
    step();
    // same-cycle dispatch and wakeup
    disp(mk(5'h6, 6'h09, 6'h05, 5'd3, 5'd4), 2'b01);
    wb_valid_rb0 = 1'b1;
    wb_pdst_rb0 = 6'h05;
    step();
    idle();
    #1;
    chk("samewake_issue", issue_valid_rs1, 1);
    chk("samewake_robid", issue_rs1.robid, 5'h6);
    step();

    // fill all entries, drop the ninth, free one via wakeup
    for (int k = 0; k < N; k++) begin
      disp(mk(t_rob_id'(k + 8), t_prf_id'(16 + k), t_prf_id'(16 + k), 5'd1, 5'd2), 2'b00);
      step();
    end
    idle();
    #1 chk("full_stall", rs_stall_ex_rs0, 1);
    disp(mk(5'h1f, 6'h01, 6'h01, 5'd0, 5'd0), 2'b11);
    step();
    idle();
    wb_valid_rb0 = 1'b1;
    wb_pdst_rb0 = 6'h13;
    step();
    idle();
    #1;
    chk("full_issue_valid", issue_valid_rs1, 1);
    chk("full_issue_robid", issue_rs1.robid, 5'd11);
    chk("full_no_credit", rs_stall_ex_rs0, 1);
    step();
    #1 chk("full_stall_drop", rs_stall_ex_rs0, 0);
    nuke_rb1 = 1'b1;
    step();
    idle();

    // execution back-pressure holds the same uop until released
    disp(mk(5'h7, 6'h01, 6'h02, 5'd1, 5'd2), 2'b11);
    step();
    idle();
    ex_stall_rs1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("exst_valid", issue_valid_rs1, 1);
      chk("exst_robid", issue_rs1.robid, 5'h7);
      step();
    end
    ex_stall_rs1 = 1'b0;
    step();
    #1 chk("exst_freed", issue_valid_rs1, 0);

    // flush with five valid entries and a same-cycle dispatch
    for (int k = 0; k < 4; k++) begin
      disp(mk(t_rob_id'(k + 16), t_prf_id'(40 + k), t_prf_id'(40 + k), 5'd1, 5'd2), 2'b00);
      step();
    end
    disp(mk(5'h15, 6'h01, 6'h02, 5'd1, 5'd2), 2'b11);
    step();
    idle();
    ex_stall_rs1 = 1'b1;
    step();
    ex_stall_rs1 = 1'b0;
    nuke_rb1 = 1'b1;
    disp(mk(5'h16, 6'h01, 6'h02, 5'd1, 5'd2), 2'b11);
    #1 chk("nuke_suppress", issue_valid_rs1, 0);
    step();
    idle();
    #1;
    chk("nuke_empty", issue_valid_rs1, 0);
    chk("nuke_stall", rs_stall_ex_rs0, 0);
    step();
    #1 chk("nuke_dropped", issue_valid_rs1, 0);

    // age order: A lands in entry 2, B in entry 0, both woken together
    a_id = 5'h0a;
    b_id = 5'h0b;
    disp(mk(5'h01, 6'h20, 6'h20, 5'd1, 5'd1), 2'b00);
    step();
    disp(mk(5'h02, 6'h21, 6'h21, 5'd1, 5'd1), 2'b00);
    step();
    disp(mk(a_id, 6'h30, 6'h30, 5'd1, 5'd1), 2'b00);
    step();
    idle();
    wb_valid_rb0 = 1'b1;
    wb_pdst_rb0 = 6'h20;
    step();
    idle();
    step();
    disp(mk(b_id, 6'h30, 6'h30, 5'd1, 5'd1), 2'b00);
    step();
    idle();
    wb_valid_rb0 = 1'b1;
    wb_pdst_rb0 = 6'h30;
    step();
    idle();
    #1;
`ifdef RS_AGE_ORDER_EN
    chk("age_first", issue_rs1.robid, a_id);
`else
    chk("age_first", issue_rs1.robid, b_id);
`endif
    step();
    nuke_rb1 = 1'b1;
    step();
    idle();

    // randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      disp_valid_ex_rs0 = ($urandom_range(0, 1) == 1);
      disp_ex_rs0 = mk(5'($urandom), t_prf_id'($urandom_range(0, 15)), t_prf_id'($urandom_range(0, 15)),
                       t_opreg'($urandom_range(0, 3)), t_opreg'($urandom_range(0, 3)));
      src_rdy_ex_rs0 = 2'($urandom);
      wb_valid_rb0 = ($urandom_range(0, 9) < 4);
      wb_pdst_rb0 = t_prf_id'($urandom_range(0, 15));
      ex_stall_rs1 = ($urandom_range(0, 3) == 0);
      nuke_rb1 = ($urandom_range(0, 29) == 0);
      step();
    end
    idle();

    // asynchronous reset between edges
    for (int k = 0; k < N; k++) begin
      disp(mk(5'(k), 6'h3f, 6'h3f, 5'd1, 5'd1), 2'b00);
      step();
    end
    idle();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_stall", rs_stall_ex_rs0, 0);
    chk("async_rst_issue", issue_valid_rs1, 0);
    m_clear();
    #1 reset = 1'b1;
    @(negedge clk);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_eint.md
RS_EINT -- requirements
Module: rs_eint

Interface
REQ-001 SHALL have parameter NUM_RS_ENTRIES, default 8, meaning the number of reservation-station entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port disp_valid_ex_rs0, input, 1 bit: dispatch valid from alloc.
REQ-005 SHALL have port disp_ex_rs0, input, t_uinstr_disp: dispatched uop (uinstr, robid, rename).
REQ-006 SHALL have port src_rdy_ex_rs0, input, logic [NUM_SOURCES-1:0]: per-source ready at dispatch.
REQ-007 SHALL have port rs_stall_ex_rs0, output, 1 bit: back-pressure to alloc.
REQ-008 SHALL have port wb_valid_rb0, input, 1 bit: writeback wakeup broadcast valid.
REQ-009 SHALL have port wb_pdst_rb0, input, t_prf_id: physical register being written.
REQ-010 SHALL have port nuke_rb1, input, 1 bit: pipeline flush.
REQ-011 SHALL have port ex_stall_rs1, input, 1 bit: execution unit cannot accept an issue.
REQ-012 SHALL have port issue_valid_rs1, output, 1 bit: issue valid.
REQ-013 SHALL have port issue_rs1, output, t_uinstr_disp: issued uop.

Function
REQ-014 SHALL keep, per entry: valid bit, t_uinstr_disp payload, and one ready bit per source.
REQ-015 SHALL, on disp_valid_ex_rs0 & ~rs_stall_ex_rs0 & ~nuke_rb1, write into the lowest-index free entry at the clock edge.
REQ-016 SHALL set each source ready bit on write = src_rdy_ex_rs0[i] | (wb_valid_rb0 & wb_pdst_rb0 == that psrc) | (source opreg == 0).
REQ-017 SHALL set, on wb_valid_rb0, the ready bit of every valid entry source whose psrc equals wb_pdst_rb0, effective the next cycle.
REQ-018 SHALL treat an entry as eligible when it is valid and all its source ready bits are set.
REQ-019 SHALL drive issue_valid_rs1 combinationally = any eligible entry & ~nuke_rb1, with issue_rs1 = payload of the selected entry.
REQ-020 SHALL clear the selected entry's valid bit at the edge when issue_valid_rs1 & ~ex_stall_rs1; under ex_stall_rs1 the entry is kept and the selection may change the next cycle.
REQ-021 SHALL give minimum dispatch-to-issue latency of 1 cycle: dispatched with all sources ready at N, issue_valid_rs1 in N+1.
REQ-022 SHALL assert rs_stall_ex_rs0 combinationally when all entries are valid, without crediting a same-cycle issue.
REQ-023 SHALL ignore disp_valid_ex_rs0 while rs_stall_ex_rs0 is high; no entry is written.
REQ-024 SHALL, on nuke_rb1, clear all valid bits at the edge; nuke takes priority over a same-cycle dispatch (dropped) and a same-cycle issue (suppressed).
REQ-025 SHALL allow dispatch, wakeup and issue in the same cycle, in different entries.

Reset
REQ-026 SHALL clear all entry valid bits on reset low, asynchronously.
REQ-027 SHALL have, during and after reset: issue_valid_rs1=0, rs_stall_ex_rs0=0, issue_rs1=all zeros; payload and ready bits need no reset.

Configuration
REQ-028 SHALL, with RS_AGE_ORDER_EN defined, select the oldest eligible entry using a NUM_RS_ENTRIES x NUM_RS_ENTRIES age matrix updated on write.
REQ-029 SHALL, without RS_AGE_ORDER_EN, select the lowest-index eligible entry and contain no age-matrix state.

Structure
REQ-030 SHALL define t_rs_id and the NUM_RS_ENTRIES default in common.pkg; t_uinstr_disp and t_prf_id come from the existing packages.
REQ-031 SHALL implement the age matrix and oldest-pick as sub-module rs_age_matrix, instantiated only under RS_AGE_ORDER_EN.
REQ-032 SHALL report issue under SIMULATION with UINFO "unit:RS" (robid, pdst), like the other pipeline units.

Verification
REQ-033 SHALL cover: dispatch robid 0x3 with both sources ready in cycle 10 -> issue_valid_rs1=1 with robid 0x3 in cycle 11, entry freed in cycle 12.
REQ-034 SHALL cover: dispatch with psrc1=0x5 not ready, wb_valid_rb0 with wb_pdst_rb0=0x5 two cycles later -> issue exactly 1 cycle after the wakeup; same-cycle dispatch+wakeup -> issue the next cycle.
REQ-035 SHALL cover: 8 dispatches with no source ready -> rs_stall_ex_rs0=1 after the 8th; a 9th disp_valid is dropped; one wakeup+issue -> stall drops the cycle after the issue edge.
REQ-036 SHALL cover: ex_stall_rs1 held 3 cycles with one eligible entry -> issue_valid_rs1 stays 1, same robid; the entry frees after ex_stall_rs1 falls.
REQ-037 SHALL cover: nuke_rb1 with 5 valid entries plus a same-cycle dispatch -> all entries empty next cycle, issue_valid_rs1=0 in the nuke cycle, stall=0.
REQ-038 SHALL cover: with RS_AGE_ORDER_EN, dispatch A into entry 2 and then B into entry 0, both woken together -> A issues first; without the macro, B issues first.
